phase_sequencer: RTL

- Sits directly downstream of the strobe generator and upstream of the CORDIC core.
- On each sample strobe, it samples a phase accumulator and folds the phase into the CORDIC's ±pi/2 convergence range.
- It launches one CORDIC rotation, waits for done, un-folds the result (sign correction), and presents a registered sin/cos sample with a one-cycle valid pulse.
- It also detects strobes that arrive while a rotation is still in flight.

---
 rtl/phase_sequencer_pkg.sv | 26 ++
 rtl/phase_sequencer_phase_folder.sv | 25 ++
 rtl/phase_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared types and helpers for the phase sequencer and the CORDIC core it feeds.
package phase_sequencer_pkg;

    // Default widths shared with the CORDIC core.
    localparam int unsigned BW_PHASE_DEF = 16;
    localparam int unsigned BW_DATA_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } seq_state_e;

    // Two's complement negate of a width-bit value carried sign-extended in 32 bits;
    // the most negative value maps to the most positive one instead of overflowing.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] val,
                                                   input int unsigned       width);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (width - 1));
        if (val == min_v) begin
            return (32'sd1 <<< (width - 1)) - 32'sd1;
        end
        return -val;
    endfunction

endpackage

// File: rtl/phase_sequencer_phase_folder.sv
// Folds an unsigned phase into the CORDIC's +/-pi/2 range (truncating slice).
module phase_folder
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned BW_PHASE = BW_PHASE_DEF,
    parameter int unsigned BW_DATA  = BW_DATA_DEF
) (
    input  logic [BW_PHASE-1:0] acc_i,
    output logic [BW_DATA-1:0]  angle_o,
    output logic                neg_o
);

    logic [BW_PHASE-1:0] folded;

    // Quadrants 2/3 are shifted by pi (MSB flip) and flagged for sign correction.
    always_comb begin
        folded = acc_i;
        neg_o  = acc_i[BW_PHASE-1] ^ acc_i[BW_PHASE-2];
        if (neg_o) begin
            folded[BW_PHASE-1] = ~acc_i[BW_PHASE-1];
        end
        angle_o = folded[BW_PHASE-1 -: BW_DATA];
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: per strobe, fold the accumulated phase, run one CORDIC rotation,
// un-fold the result and emit a registered sin/cos sample with a valid pulse.
// Optional macro PHASE_SEQ_OVERRUN_COUNT_EN adds an 8-bit saturating dropped-strobe counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned BW_PHASE = BW_PHASE_DEF,
    parameter int unsigned BW_DATA  = BW_DATA_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                strobe_i,
    input  logic [BW_PHASE-1:0] phase_inc_i,
    output logic                cordic_start_o,
    output logic [BW_DATA-1:0]  cordic_angle_o,
    input  logic                cordic_done_i,
    input  logic [BW_DATA-1:0]  cordic_sin_i,
    input  logic [BW_DATA-1:0]  cordic_cos_i,
    output logic [BW_DATA-1:0]  sin_o,
    output logic [BW_DATA-1:0]  cos_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                overrun_o
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
    ,
    output logic [7:0]          overrun_cnt_o
`endif
);

    seq_state_e          state_q, state_d;
    logic [BW_PHASE-1:0] acc_q, acc_d;
    logic [BW_DATA-1:0]  angle_q, angle_d;
    logic                neg_q, neg_d;
    logic                start_q, start_d;
    logic [BW_DATA-1:0]  sin_q, sin_d;
    logic [BW_DATA-1:0]  cos_q, cos_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
    logic [7:0]          cnt_q, cnt_d;
`endif

    logic [BW_DATA-1:0]  fold_angle;
    logic                fold_neg;
    logic [BW_DATA-1:0]  sin_fix, cos_fix;

    phase_folder #(
        .BW_PHASE (BW_PHASE),
        .BW_DATA  (BW_DATA)
    ) u_folder (
        .acc_i   (acc_q),
        .angle_o (fold_angle),
        .neg_o   (fold_neg)
    );

    // Sign-correct the incoming CORDIC result using the flag of the rotation in flight.
    always_comb begin
        sin_fix = cordic_sin_i;
        cos_fix = cordic_cos_i;
        if (neg_q) begin
            sin_fix = BW_DATA'(sat_neg(32'(signed'(cordic_sin_i)), BW_DATA));
            cos_fix = BW_DATA'(sat_neg(32'(signed'(cordic_cos_i)), BW_DATA));
        end
    end

    // Next-state logic; done and strobe in the same WAIT cycle both capture and relaunch.
    always_comb begin
        logic accept;
        logic drop;
        state_d   = state_q;
        acc_d     = acc_q;
        angle_d   = angle_q;
        neg_d     = neg_q;
        start_d   = 1'b0;
        sin_d     = sin_q;
        cos_d     = cos_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
        cnt_d     = cnt_q;
`endif
        accept    = 1'b0;
        drop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = strobe_i;
            end
            LAUNCH: begin
                state_d = WAIT;
                drop    = strobe_i;
            end
            WAIT: begin
                if (cordic_done_i) begin
                    sin_d   = sin_fix;
                    cos_d   = cos_fix;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    accept  = strobe_i;
                end else begin
                    drop = strobe_i;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            angle_d = fold_angle;
            neg_d   = fold_neg;
            acc_d   = acc_q + phase_inc_i;
            start_d = 1'b1;
            state_d = LAUNCH;
        end

        if (drop) begin
            acc_d     = acc_q + phase_inc_i;
            overrun_d = 1'b1;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
`endif
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            angle_q   <= '0;
            neg_q     <= 1'b0;
            start_q   <= 1'b0;
            sin_q     <= '0;
            cos_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            angle_q   <= angle_d;
            neg_q     <= neg_d;
            start_q   <= start_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign cordic_start_o = start_q;
    assign cordic_angle_o = angle_q;
    assign sin_o          = sin_q;
    assign cos_o          = cos_q;
    assign valid_o        = valid_q;
    assign busy_o         = (state_q != IDLE);
    assign overrun_o      = overrun_q;
`ifdef PHASE_SEQ_OVERRUN_COUNT_EN
    assign overrun_cnt_o  = cnt_q;
`endif

endmodule
